// File: rtl/cart_bus_sequencer_pkg.sv
// Shared cartridge-port types: buffer direction, sequencer states
// and the captured request bundle.
package pocket;

  localparam int CART_DATA_W = 8;
  localparam int CART_ADDR_W = 16;

  typedef enum logic {
    DIR_IN  = 1'b0,
    DIR_OUT = 1'b1
  } dir_e;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    TURN
  } cart_bus_state_e;

  typedef struct packed {
    logic                   write;
    logic [CART_ADDR_W-1:0] addr;
    logic [CART_DATA_W-1:0] wdata;
  } cart_bus_req_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cart_bus_sequencer_sync.sv
// Two-flop synchronizer for the cartridge read data path.
// Used by cart_bus_sequencer only when CART_BUS_SYNC_EN is defined.
module cart_bus_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cart_bus_sequencer.sv
// Cartridge bus-cycle sequencer: setup, strobe, turnaround per request.
// Define CART_BUS_SYNC_EN to synchronize data_in and stretch read strobes.
module cart_bus_sequencer
  import pocket::*;
#(
  parameter int DATA_WIDTH    = CART_DATA_W,
  parameter int ADDR_WIDTH    = CART_ADDR_W,
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int TURN_CYCLES   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_rd,
  output logic                  bus_wr,
  output dir_e                  dir,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  busy
);

`ifdef CART_BUS_SYNC_EN
  localparam int SYNC_EXT = 2;
`else
  localparam int SYNC_EXT = 0;
`endif

  localparam int RD_CYCLES = STROBE_CYCLES + SYNC_EXT;
  localparam int CW =
    $clog2(max3(SETUP_CYCLES, RD_CYCLES, TURN_CYCLES) + 1);

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] WR_LD    = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LD    = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] TURN_LD  = CW'(TURN_CYCLES - 1);

  cart_bus_state_e       state;
  logic [CW-1:0]         cnt;
  cart_bus_req_t         req_q;
  logic [DATA_WIDTH-1:0] sample;

`ifdef CART_BUS_SYNC_EN
  cart_bus_sync #(
    .WIDTH(DATA_WIDTH)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (data_in),
    .q    (sample)
  );
`else
  assign sample = data_in;
`endif

  // Address and write data come straight from the captured request.
  assign bus_addr = req_q.addr;
  assign data_out = req_q.wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      req_q     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      bus_rd    <= 1'b0;
      bus_wr    <= 1'b0;
      dir       <= DIR_IN;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            state       <= SETUP;
            cnt         <= SETUP_LD;
            req_q.write <= req_write;
            req_q.addr  <= req_addr;
            if (req_write) req_q.wdata <= req_wdata;
            dir         <= req_write ? DIR_OUT : DIR_IN;
            req_ready   <= 1'b0;
            busy        <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state  <= STROBE;
            cnt    <= req_q.write ? WR_LD : RD_LD;
            bus_wr <= req_q.write;
            bus_rd <= !req_q.write;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            state  <= TURN;
            cnt    <= TURN_LD;
            bus_wr <= 1'b0;
            bus_rd <= 1'b0;
            dir    <= DIR_IN;
            if (!req_q.write) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= sample;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        TURN: begin
          if (cnt == '0) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cart_bus_sequencer.sv
// Randomized bench for cart_bus_sequencer against a cycle-offset model.
// Honours CART_BUS_SYNC_EN for the stretched read timing.
module tb_cart_bus_sequencer;
  import pocket::*;

  localparam int S  = 2;
  localparam int ST = 4;
  localparam int T  = 1;
`ifdef CART_BUS_SYNC_EN
  localparam int EXT = 2;
  localparam logic [10:0] RD_MASK  = 11'h1F8;
  localparam logic [10:0] RSP_MASK = 11'h200;
`else
  localparam int EXT = 0;
  localparam logic [10:0] RD_MASK  = 11'h078;
  localparam logic [10:0] RSP_MASK = 11'h080;
`endif
  localparam int SLR = ST + EXT;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [15:0] bus_addr;
  logic        bus_rd;
  logic        bus_wr;
  dir_e        dir;
  logic [7:0]  data_out;
  logic [7:0]  data_in;
  logic        busy;

  cart_bus_sequencer #(
    .DATA_WIDTH   (8),
    .ADDR_WIDTH   (16),
    .SETUP_CYCLES (S),
    .STROBE_CYCLES(ST),
    .TURN_CYCLES  (T)
  ) dut (
    .clk      (clk),
    .reset    (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .bus_addr (bus_addr),
    .bus_rd   (bus_rd),
    .bus_wr   (bus_wr),
    .dir      (dir),
    .data_out (data_out),
    .data_in  (data_in),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  logic [7:0] rd_val = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: position within the bus cycle, counted from accept.
  bit          m_busy = 0;
  int          m_off  = 0;
  bit          m_w    = 0;
  bit          m_rsp  = 0;
  logic [15:0] m_addr = '0;
  logic [7:0]  m_wd   = '0;
  logic [7:0]  m_rd   = '0;
  logic [7:0]  h1     = '0;
  logic [7:0]  h2     = '0;

  initial begin
    logic [7:0] samp;
    int sl;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_busy = 0; m_off = 0; m_w = 0; m_rsp = 0;
        m_addr = '0; m_wd = '0; m_rd = '0; h1 = '0; h2 = '0;
      end else begin
        samp  = (EXT != 0) ? h2 : data_in;
        m_rsp = 0;
        if (m_busy) begin
          m_off++;
          sl = m_w ? ST : SLR;
          if (!m_w && m_off == S + SLR + 1) begin
            m_rsp = 1;
            m_rd  = samp;
          end
          if (m_off == S + sl + T + 1) m_busy = 0;
        end else if (req_valid) begin
          m_busy = 1;
          m_off  = 1;
          m_w    = req_write;
          m_addr = req_addr;
          if (req_write) m_wd = req_wdata;
        end
        h2 = h1;
        h1 = data_in;
      end
    end
  end

  initial begin
    int  sl;
    bit  e_str;
    bit  e_dir;
    forever begin
      @(negedge clk);
      sl    = m_w ? ST : SLR;
      e_str = m_busy && m_off > S && m_off <= S + sl;
      e_dir = m_busy && m_w && m_off <= S + ST;
      chk("req_ready", 32'(req_ready), 32'(!m_busy));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("bus_wr", 32'(bus_wr), 32'(e_str && m_w));
      chk("bus_rd", 32'(bus_rd), 32'(e_str && !m_w));
      chk("dir", 32'(dir), 32'(e_dir));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rd));
      chk("bus_addr", 32'(bus_addr), 32'(m_addr));
      chk("data_out", 32'(data_out), 32'(m_wd));
    end
  end

  // Read data is held steady while the read strobe is up.
  initial begin
    data_in = '0;
    forever begin
      @(posedge clk);
      #2;
      data_in = bus_rd ? rd_val : 8'($urandom);
    end
  end

  task automatic issue(input bit w, input logic [15:0] a,
                       input logic [7:0] d, output int acc);
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    acc = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      vectors++;
      errors++;
      $display("FAIL accept_timeout: got none expected accept");
    end
  endtask

  task automatic observe(output logic [10:0] wr, output logic [10:0] rd,
                         output logic [10:0] dout, output logic [10:0] rdy,
                         output logic [10:0] rsp, output logic [7:0] rdata,
                         output logic [7:0] d1);
    wr = '0; rd = '0; dout = '0; rdy = '0; rsp = '0;
    rdata = '0; d1 = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      wr[i]   = bus_wr;
      rd[i]   = bus_rd;
      dout[i] = (dir == DIR_OUT);
      rdy[i]  = req_ready;
      rsp[i]  = rsp_valid;
      if (rsp_valid) rdata = rsp_rdata;
      if (i == 1) d1 = data_out;
    end
  endtask

  initial begin
    int a1, a2;
    logic [10:0] wr, rd, dout, rdy, rsp;
    logic [7:0]  rdata, d1;
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_dir", 32'(dir), 32'(DIR_IN));
    rst = 1'b0;

    repeat (5) begin
      @(negedge clk);
      chk("idle_ready", 32'(req_ready), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_strobe", 32'({bus_rd, bus_wr}), 32'd0);
    end

    @(posedge clk); #1;
    issue(1'b1, 16'h1234, 8'hA5, a1);
    req_valid = 1'b0;
    observe(wr, rd, dout, rdy, rsp, rdata, d1);
    chk("wr_strobe", 32'(wr), 32'h078);
    chk("wr_dir_out", 32'(dout), 32'h07E);
    chk("wr_ready", 32'(rdy), 32'h700);
    chk("wr_no_rsp", 32'(rsp), 32'h000);
    chk("wr_data", 32'(d1), 32'hA5);

    rd_val = 8'h3C;
    issue(1'b0, 16'h0100, 8'h00, a1);
    req_valid = 1'b0;
    observe(wr, rd, dout, rdy, rsp, rdata, d1);
    chk("rd_strobe", 32'(rd), 32'(RD_MASK));
    chk("rd_dir_in", 32'(dout), 32'h000);
    chk("rd_rsp", 32'(rsp), 32'(RSP_MASK));
    chk("rd_data", 32'(rdata), 32'h3C);
    repeat (3) @(posedge clk); #1;

    issue(1'b1, 16'hBEEF, 8'h77, a1);
    rd_val = 8'hC3;
    issue(1'b0, 16'h0200, 8'h00, a2);
    req_valid = 1'b0;
    chk("b2b_spacing", 32'(a2 - a1), 32'd8);
    observe(wr, rd, dout, rdy, rsp, rdata, d1);
    chk("b2b_rd_strobe", 32'(rd), 32'(RD_MASK));
    chk("b2b_dir_in", 32'(dout), 32'h000);
    chk("b2b_rd_data", 32'(rdata), 32'hC3);
    repeat (3) @(posedge clk); #1;

    issue(1'b1, 16'h4321, 8'h99, a1);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_wr_pre", 32'(bus_wr), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_wr", 32'(bus_wr), 32'd0);
    chk("mid_rst_dir", 32'(dir), 32'(DIR_IN));
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    rd_val = 8'h5A;
    issue(1'b0, 16'h0055, 8'h00, a1);
    req_valid = 1'b0;
    observe(wr, rd, dout, rdy, rsp, rdata, d1);
    chk("post_rst_rsp", 32'(rsp), 32'(RSP_MASK));
    chk("post_rst_data", 32'(rdata), 32'h5A);

    for (int k = 0; k < 60; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      rd_val = 8'($urandom);
      issue(1'($urandom), 16'($urandom), 8'($urandom), a1);
      req_write = 1'($urandom);
      req_addr  = 16'($urandom);
      req_wdata = 8'($urandom);
      if ($urandom_range(0, 1) == 0) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    repeat (16) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
